// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: data bus type, FSM state encoding and the latched request.
package load_store_unit_pkg;

  localparam int LSU_ADDR_W = 6;
  localparam int LSU_DEPTH  = 32;

  typedef logic [31:0] bus_type;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    RESP    = 2'd3
  } lsu_state_t;

  typedef struct packed {
    logic                  write;
    logic [LSU_ADDR_W-1:0] addr;
    bus_type               wdata;
  } lsu_req_t;

  function automatic logic lsu_in_range(input logic [LSU_ADDR_W-1:0] addr, input int depth);
    return (int'(addr) < depth);
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store initiator for the data memory: one request at a time, absorbs the 1-cycle read latency.
// Optional LSU_RANGE_CHECK_EN: out-of-range addresses answer with resp_error and never reach memory.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DEPTH  = LSU_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  bus_type           req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output bus_type           resp_rdata,
  output logic              resp_error,
  output logic [ADDR_W-1:0] mem_address,
  output bus_type           mem_input_data,
  output logic              mem_enable_read,
  output logic              mem_enable_write,
  input  bus_type           mem_read_data
);

`ifdef LSU_RANGE_CHECK_EN
  localparam logic RANGE_CHECK = 1'b1;
`else
  localparam logic RANGE_CHECK = 1'b0;
`endif

  lsu_state_t state_q, state_d;
  lsu_req_t   req_q, req_d;
  logic       valid_q, valid_d;
  bus_type    rdata_q, rdata_d;
  logic       error_q, error_d;
  logic       en_rd_q, en_rd_d;
  logic       en_wr_q, en_wr_d;
  logic       accept_s;
  logic       oor_s;

  assign accept_s = req_valid && (state_q == IDLE);
  assign oor_s    = RANGE_CHECK & ~lsu_in_range(req_addr, DEPTH);

  // Next-state and holding-register updates; enables are computed one cycle ahead so they leave flops.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    valid_d = valid_q;
    rdata_d = rdata_q;
    error_d = error_q;
    en_rd_d = 1'b0;
    en_wr_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          req_d.write = req_write;
          req_d.addr  = req_addr;
          req_d.wdata = req_write ? req_wdata : 32'h0;
          if (oor_s) begin
            state_d = RESP;
            valid_d = 1'b1;
            rdata_d = 32'h0;
            error_d = 1'b1;
          end else begin
            state_d = ISSUE;
            en_rd_d = ~req_write;
            en_wr_d = req_write;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        if (req_q.write) begin
          state_d = RESP;
          valid_d = 1'b1;
          rdata_d = 32'h0;
          error_d = 1'b0;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        state_d = RESP;
        valid_d = 1'b1;
        rdata_d = mem_read_data;
        error_d = 1'b0;
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          rdata_d = 32'h0;
          error_d = 1'b0;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        rdata_d = 32'h0;
        error_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset drops the memory enables immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= '{write: 1'b0, addr: {LSU_ADDR_W{1'b0}}, wdata: 32'h0};
      valid_q <= 1'b0;
      rdata_q <= 32'h0;
      error_q <= 1'b0;
      en_rd_q <= 1'b0;
      en_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
      en_rd_q <= en_rd_d;
      en_wr_q <= en_wr_d;
    end
  end

  assign req_ready        = (state_q == IDLE);
  assign resp_valid       = valid_q;
  assign resp_rdata       = rdata_q;
  assign resp_error       = error_q;
  assign mem_address      = req_q.addr;
  assign mem_input_data   = req_q.wdata;
  assign mem_enable_read  = en_rd_q;
  assign mem_enable_write = en_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed table, reset/back-to-back sequences, random traffic.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

`ifdef LSU_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  bus_type    req_wdata;
  logic       resp_valid, resp_ready;
  bus_type    resp_rdata;
  logic       resp_error;
  logic [5:0] mem_address;
  bus_type    mem_input_data;
  logic       mem_enable_read, mem_enable_write;
  bus_type    mem_read_data;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_input_data(mem_input_data),
    .mem_enable_read(mem_enable_read), .mem_enable_write(mem_enable_write),
    .mem_read_data(mem_read_data)
  );

  function automatic bus_type init_word(input int i);
    return 32'hC0DE_0000 | bus_type'(i);
  endfunction

  // Data memory stand-in: 64 words, registered read, write on enable.
  bus_type stub_mem [64];
  logic    mem_clear;
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 64; i++) stub_mem[i] <= init_word(i);
    end else begin
      if (mem_enable_write) stub_mem[mem_address] <= mem_input_data;
      if (mem_enable_read)  mem_read_data <= stub_mem[mem_address];
    end
  end

  bus_type ref_mem [64];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // One request end to end, expected timing derived from the request kind.
  task automatic run_txn(input logic wr, input logic [5:0] a, input bus_type d, input int bp,
                         input bus_type exp_rdata, input logic exp_err);
    int lat, wr_cnt, rd_cnt, bad_t, exp_lat;
    logic [5:0] seen_addr;
    bus_type seen_din, r0;
    bit acc;
    exp_lat = exp_err ? 1 : (wr ? 2 : 3);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; resp_ready = 1'b0;
    acc = 1'b0;
    for (int w = 0; w < 20; w++) begin
      if (req_ready) begin acc = 1'b1; break; end
      @(negedge clk);
    end
    chk("accept", 32'(acc), 32'd1);
    if (!acc) begin req_valid = 1'b0; return; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 6'($urandom); req_wdata = $urandom;
    lat = 0; wr_cnt = 0; rd_cnt = 0; bad_t = 0; seen_addr = 6'd0; seen_din = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_enable_write || mem_enable_read) begin
        if (k != 1) bad_t++;
        seen_addr = mem_address; seen_din = mem_input_data;
      end
      wr_cnt += int'(mem_enable_write);
      rd_cnt += int'(mem_enable_read);
      if (resp_valid) begin lat = k; break; end
      @(negedge clk);
    end
    chk("latency", lat, exp_lat);
    chk("wr_pulses", wr_cnt, (wr && !exp_err) ? 1 : 0);
    chk("rd_pulses", rd_cnt, (!wr && !exp_err) ? 1 : 0);
    chk("en_timing", bad_t, 0);
    if (!exp_err) begin
      chk("mem_addr", 32'(seen_addr), 32'(a));
      if (wr) chk("mem_wdata", seen_din, d);
    end
    chk("rdata", resp_rdata, exp_rdata);
    chk("error", 32'(resp_error), 32'(exp_err));
    r0 = resp_rdata;
    for (int b = 0; b < bp; b++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_rdata", resp_rdata, r0);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_noen", 32'({mem_enable_read, mem_enable_write}), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", 32'(resp_valid), 32'd0);
    chk("post_ready", 32'(req_ready), 32'd1);
    if (wr && !exp_err) ref_mem[a] = d;
  endtask

  typedef struct {
    logic       wr;
    logic [5:0] addr;
    bus_type    wdata;
    int         bp;
    bus_type    exp_rdata;
    logic       exp_err;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    int first_ready, first_resp, lat;
    logic oor;
    bus_type exp;
    logic wr;
    logic [5:0] a;
    bus_type d;

    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    vecs[0]  = '{1'b1, 6'd5,  32'hDEAD_BEEF, 0, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 6'd5,  32'h0,         0, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 6'd0,  32'h0123_4567, 1, 32'h0,         1'b0};
    vecs[3]  = '{1'b1, 6'd31, 32'h89AB_CDEF, 0, 32'h0,         1'b0};
    vecs[4]  = '{1'b0, 6'd0,  32'h0,         5, 32'h0123_4567, 1'b0};
    vecs[5]  = '{1'b0, 6'd31, 32'h0,         0, 32'h89AB_CDEF, 1'b0};
    vecs[6]  = '{1'b0, 6'd12, 32'h0,         0, 32'hC0DE_000C, 1'b0};
    vecs[7]  = '{1'b1, 6'd40, 32'hA5A5_5A5A, 0, 32'h0,         RC};
    vecs[8]  = '{1'b0, 6'd40, 32'h0,         2, RC ? 32'h0 : 32'hA5A5_5A5A, RC};
    vecs[9]  = '{1'b1, 6'd5,  32'h0,         0, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 6'd5,  32'h0,         0, 32'h0,         1'b0};

    rst_n = 1'b0; mem_clear = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 6'd0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_error", 32'(resp_error), 32'd0);
    chk("rst_enables", 32'({mem_enable_read, mem_enable_write}), 32'd0);
    chk("rst_mem_addr", 32'(mem_address), 32'd0);
    chk("rst_mem_din", mem_input_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    mem_clear = 1'b0;
    chk("rel_req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 11; i++)
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].bp, vecs[i].exp_rdata, vecs[i].exp_err);

    // Reset while a store sits in ISSUE: the write must never land.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd7; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    chk("issue_en_wr", 32'(mem_enable_write), 32'd1);
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    chk("rst_drops_en", 32'(mem_enable_write), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_no_write", stub_mem[7], ref_mem[7]);
    chk("rst_mid_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_valid", 32'(resp_valid), 32'd0);

    // Back-to-back store then load with req_valid held high.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd9; req_wdata = 32'hCAFE_F00D; resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_write = 1'b0; req_wdata = 32'h0;
    first_ready = 0; first_resp = 0;
    for (int k = 1; k <= 10; k++) begin
      if (resp_valid && first_resp == 0) first_resp = k;
      if (req_ready) begin first_ready = k; break; end
      @(negedge clk);
    end
    chk("b2b_store_lat", first_resp, 2);
    chk("b2b_reaccept", first_ready, 3);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      if (resp_valid) begin lat = k; break; end
      @(negedge clk);
    end
    chk("b2b_load_lat", lat, 3);
    chk("b2b_load_data", resp_rdata, 32'hCAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    ref_mem[9] = 32'hCAFE_F00D;

    for (int n = 0; n < 40; n++) begin
      wr = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(32, 63)) : 6'($urandom_range(0, 31));
      d  = $urandom;
      oor = RC && (a >= 6'd32);
      exp = (oor || wr) ? 32'h0 : ref_mem[a];
      run_txn(wr, a, d, int'($urandom_range(0, 2)), exp, oor);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
